alu_exec_seq: RTL and testbench
===============================

// Module: alu_exec_seq
// PURPOSE
//  Execute sequencer that sits directly upstream of the ALU and consumes its result.
//  Accepts decoded instructions (op + operand) over valid/ready and holds the accumulator (ACC) and carry flag.
//  Drives ALU CE/OP_CODE/operands for exactly one cycle per instruction and writes the result back to ACC.
//  OP_ST instructions are emitted on a store port toward the data-memory interface.
// PARAMETERS
//  SIZE       8    datapath width; must match the ALU SIZE
//  ACC_RST    '0   ACC value loaded on reset
// PORTS
//  CLK            in   1     clock, rising edge
//  RST_N          in   1     asynchronous active-low reset
//  instr_valid    in   1     instruction present on instr_op/instr_operand
//  instr_ready    out  1     sequencer can accept an instruction this cycle
//  instr_op       in   3     opcode, OP_CODES encoding (OP_ADD..OP_ST)
//  instr_operand  in   SIZE  right operand (immediate or fetched data)
//  alu_ce         out  1     to ALU CE
//  alu_op         out  3     to ALU OP_CODE
//  alu_left       out  SIZE  to ALU left_operand; always equals ACC
//  alu_right      out  SIZE  to ALU right_operand; latched operand
//  alu_carry      in   1     from ALU carry_out
//  alu_result     in   SIZE  from ALU op_out
//  st_valid       out  1     store data valid
//  st_ready       in   1     store sink accepts st_data
//  st_data        out  SIZE  value being stored
//  acc            out  SIZE  accumulator
//  carry_flag     out  1     carry/borrow flag
//  zero_flag      out  1     present only with ALU_ZFLAG_EN
// BEHAVIOUR
//  Reset (RST_N=0, async, takes effect immediately, also mid-instruction):
//   - state=IDLE; acc=ACC_RST; carry_flag=0; op_q=0; opnd_q=0
//   - st_valid=0; st_data=0; alu_ce=0; zero_flag=(ACC_RST==0)
//  FSM states: IDLE, EXEC, STORE.
//  - IDLE: instr_ready=1; on instr_valid, latch op_q/opnd_q and go to EXEC.
//  - EXEC: alu_ce=1; alu_op=op_q; alu_right=opnd_q. Registered outputs take their new values at the end of the cycle:
//     * ADD/SUB: acc<=alu_result; carry_flag<=alu_carry (SUB carry = borrow, 9-bit wrap).
//     * AND/OR/XOR/NOT/LD: acc<=alu_result; carry_flag unchanged.
//     * ST: acc unchanged; st_data<=alu_result; st_valid<=1; next state STORE.
//     * Non-ST: instr_ready=1 in EXEC. A new accept stays in EXEC (back-to-back, 1 instr/cycle); otherwise the FSM returns to IDLE.
//     * ST: instr_ready=0 in EXEC.
//  - STORE: alu_ce=0; instr_ready=0; st_valid and st_data held stable until st_ready.
//     * On st_valid&&st_ready: st_valid<=0 and the FSM goes to IDLE.
//     * st_ready may already be high in the first STORE cycle (completes in 1 cycle).
//  - alu_ce=0 in IDLE and STORE; alu_op/alu_right hold their last latched values.
//  Latency: accept at cycle N -> ALU evaluated at N+1 -> acc visible at N+2.
//  Forwarding: none is needed. alu_left=acc, so back-to-back instructions see the prior result.
//  The all-zero store case completes normally; there is no overflow detection beyond carry.
//  instr_valid while instr_ready=0: ignored; the upstream must hold the instruction.
// CONFIGURATION
//  ALU_ZFLAG_EN defined:
//   - zero_flag port exists; zero_flag<=(alu_result==0) on every EXEC writeback, including ST.
//   - zero_flag holds its value otherwise.
//  ALU_ZFLAG_EN undefined: zero_flag port and logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset: drive RST_N low mid-run -> acc=0, carry_flag=0, st_valid=0, instr_ready=1 immediately (async).
//  2 Back-to-back: LD 0x3C then ADD 0xD0 on consecutive cycles -> acc=0x3C, then acc=0x0C, carry_flag=1, no stall.
//  3 Borrow: acc=0x0C, SUB 0x0D -> acc=0xFF, carry_flag=1; then AND 0x0F -> acc=0x0F, carry_flag still 1.
//  4 Store stall: acc=0xA5, ST with st_ready low 3 cycles -> st_valid=1, st_data=0xA5 stable, instr_ready=0; st_ready=1 -> done, IDLE.
//  5 Reset in STORE: assert RST_N=0 while st_valid=1 -> st_valid=0 asynchronously; after release the first instruction executes normally.
//  6 ALU_ZFLAG_EN: acc=0x55, XOR 0x55 -> acc=0x00, zero_flag=1; next OR 0x01 -> zero_flag=0.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Execute sequencer in front of the ALU: holds ACC/carry, issues one ALU op per instruction, emits stores.
// Optional zero flag is built only when ALU_ZFLAG_EN is defined.
module alu_exec_seq #(
    parameter int unsigned     SIZE    = 8,
    parameter logic [SIZE-1:0] ACC_RST = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [2:0]      instr_op,
    input  logic [SIZE-1:0] instr_operand,
    output logic            alu_ce,
    output logic [2:0]      alu_op,
    output logic [SIZE-1:0] alu_left,
    output logic [SIZE-1:0] alu_right,
    input  logic            alu_carry,
    input  logic [SIZE-1:0] alu_result,
    output logic            st_valid,
    input  logic            st_ready,
    output logic [SIZE-1:0] st_data,
`ifdef ALU_ZFLAG_EN
    output logic            zero_flag,
`endif
    output logic [SIZE-1:0] acc,
    output logic            carry_flag
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_ST  = 3'd7;

    typedef enum logic [1:0] {IDLE, EXEC, STORE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [SIZE-1:0] opnd_q, opnd_d;
    logic [SIZE-1:0] acc_q, acc_d;
    logic            carry_q, carry_d;
    logic            st_valid_q, st_valid_d;
    logic [SIZE-1:0] st_data_q, st_data_d;
`ifdef ALU_ZFLAG_EN
    logic            zero_q, zero_d;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            op_q       <= '0;
            opnd_q     <= '0;
            acc_q      <= ACC_RST;
            carry_q    <= 1'b0;
            st_valid_q <= 1'b0;
            st_data_q  <= '0;
`ifdef ALU_ZFLAG_EN
            zero_q     <= (ACC_RST == '0);
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            opnd_q     <= opnd_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            st_valid_q <= st_valid_d;
            st_data_q  <= st_data_d;
`ifdef ALU_ZFLAG_EN
            zero_q     <= zero_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        st_valid_d  = st_valid_q;
        st_data_d   = st_data_q;
`ifdef ALU_ZFLAG_EN
        zero_d      = zero_q;
`endif
        instr_ready = 1'b0;
        alu_ce      = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    op_d    = instr_op;
                    opnd_d  = instr_operand;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_ce = 1'b1;
`ifdef ALU_ZFLAG_EN
                zero_d = (alu_result == '0);
`endif
                if (op_q == OP_ST) begin
                    st_data_d  = alu_result;
                    st_valid_d = 1'b1;
                    state_d    = STORE;
                end else begin
                    acc_d = alu_result;
                    if (op_q == OP_ADD || op_q == OP_SUB)
                        carry_d = alu_carry;
                    // Accepting here keeps the pipe full: the next op sees the new ACC via alu_left.
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        op_d    = instr_op;
                        opnd_d  = instr_operand;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            STORE: begin
                if (st_ready) begin
                    st_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_op     = op_q;
    assign alu_left   = acc_q;
    assign alu_right  = opnd_q;
    assign acc        = acc_q;
    assign carry_flag = carry_q;
    assign st_valid   = st_valid_q;
    assign st_data    = st_data_q;
`ifdef ALU_ZFLAG_EN
    assign zero_flag  = zero_q;
`endif

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: directed table, multi-cycle corner sequences, randomized run vs a reference model.
// The bench contains a behavioural ALU driving alu_result/alu_carry.
module tb_alu_exec_seq;

    localparam int SZ = 8;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, NOT_ = 3'd5, LD = 3'd6, ST = 3'd7;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [2:0]    instr_op = '0;
    logic [SZ-1:0] instr_operand = '0;
    logic          alu_ce;
    logic [2:0]    alu_op;
    logic [SZ-1:0] alu_left, alu_right;
    logic          alu_carry;
    logic [SZ-1:0] alu_result;
    logic          st_valid;
    logic          st_ready = 1'b0;
    logic [SZ-1:0] st_data;
    logic [SZ-1:0] acc;
    logic          carry_flag;
`ifdef ALU_ZFLAG_EN
    logic          zero_flag;
`endif

    int checks = 0;
    int errors = 0;

    alu_exec_seq #(.SIZE(SZ), .ACC_RST('0)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_operand(instr_operand),
        .alu_ce(alu_ce), .alu_op(alu_op), .alu_left(alu_left), .alu_right(alu_right),
        .alu_carry(alu_carry), .alu_result(alu_result),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
`ifdef ALU_ZFLAG_EN
        .zero_flag(zero_flag),
`endif
        .acc(acc), .carry_flag(carry_flag)
    );

    always #5 CLK = ~CLK;

    // {carry, result}; SUB carry is the borrow
    function automatic logic [SZ:0] alu_fn(input logic [2:0] op, input logic [SZ-1:0] a, input logic [SZ-1:0] b);
        case (op)
            ADD:     return {1'b0, a} + {1'b0, b};
            SUB:     return {(a < b), a - b};
            AND_:    return {1'b0, a & b};
            OR_:     return {1'b0, a | b};
            XOR_:    return {1'b0, a ^ b};
            NOT_:    return {1'b0, ~a};
            LD:      return {1'b0, b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {alu_carry, alu_result} = alu_fn(alu_op, alu_left, alu_right);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [SZ-1:0] opnd);
        @(negedge CLK);
        instr_valid = 1'b1; instr_op = op; instr_operand = opnd;
        @(negedge CLK);
        instr_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]    op;
        logic [SZ-1:0] opnd;
        logic [SZ-1:0] exp_acc;
        logic          exp_c;
    } vec_t;

    vec_t tbl[10];

    // reference model state for the random phase
    logic [SZ-1:0] m_acc, m_st_data;
    logic          m_c, m_z, m_st_out, m_pend_v;
    logic [2:0]    m_pend_op;
    logic [SZ-1:0] m_pend_opnd;

    initial begin
        tbl[0] = '{LD,   8'h3C, 8'h3C, 1'b0};
        tbl[1] = '{ADD,  8'hD0, 8'h0C, 1'b1};
        tbl[2] = '{SUB,  8'h0D, 8'hFF, 1'b1};
        tbl[3] = '{AND_, 8'h0F, 8'h0F, 1'b1};
        tbl[4] = '{ADD,  8'h01, 8'h10, 1'b0};
        tbl[5] = '{OR_,  8'hA0, 8'hB0, 1'b0};
        tbl[6] = '{XOR_, 8'hFF, 8'h4F, 1'b0};
        tbl[7] = '{NOT_, 8'h00, 8'hB0, 1'b0};
        tbl[8] = '{SUB,  8'h30, 8'h80, 1'b0};
        tbl[9] = '{ST,   8'h00, 8'h80, 1'b0};

        // power-on reset
        #1 RST_N = 1'b0;
        #2;
        chk("rst_acc",      32'(acc), 32'h0);
        chk("rst_carry",    32'(carry_flag), 32'h0);
        chk("rst_st_valid", 32'(st_valid), 32'h0);
        chk("rst_st_data",  32'(st_data), 32'h0);
        chk("rst_ready",    32'(instr_ready), 32'h1);
        chk("rst_alu_ce",   32'(alu_ce), 32'h0);
        chk("rst_alu_op",   32'(alu_op), 32'h0);
        chk("rst_alu_right",32'(alu_right), 32'h0);
`ifdef ALU_ZFLAG_EN
        chk("rst_zero",     32'(zero_flag), 32'h1);
`endif
        @(negedge CLK) RST_N = 1'b1;

        // one instruction at a time; ST completes immediately with st_ready high
        st_ready = 1'b1;
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].opnd);
            @(negedge CLK);
            chk($sformatf("tbl%0d_acc", i),   32'(acc), 32'(tbl[i].exp_acc));
            chk($sformatf("tbl%0d_carry", i), 32'(carry_flag), 32'(tbl[i].exp_c));
            chk($sformatf("tbl%0d_ready", i), 32'(instr_ready), 32'(tbl[i].op != ST));
        end
        @(negedge CLK);
        chk("tbl_st_done_ready", 32'(instr_ready), 32'h1);

        // back-to-back LD then ADD, no stall
        instr_valid = 1'b1; instr_op = LD; instr_operand = 8'h3C;
        @(negedge CLK);
        chk("b2b_ready_exec", 32'(instr_ready), 32'h1);
        chk("b2b_alu_ce",     32'(alu_ce), 32'h1);
        instr_op = ADD; instr_operand = 8'hD0;
        @(negedge CLK);
        chk("b2b_acc_ld",     32'(acc), 32'h3C);
        chk("b2b_alu_left",   32'(alu_left), 32'h3C);
        instr_valid = 1'b0;
        @(negedge CLK);
        chk("b2b_acc_add",    32'(acc), 32'h0C);
        chk("b2b_carry",      32'(carry_flag), 32'h1);

        // store held off by st_ready for 3 cycles
        st_ready = 1'b0;
        issue(LD, 8'hA5);
        @(negedge CLK);
        instr_valid = 1'b1; instr_op = ST; instr_operand = 8'h00;
        @(negedge CLK);
        chk("st_exec_ready", 32'(instr_ready), 32'h0);
        instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk($sformatf("st_hold%0d_valid", k), 32'(st_valid), 32'h1);
            chk($sformatf("st_hold%0d_data", k),  32'(st_data), 32'hA5);
            chk($sformatf("st_hold%0d_ready", k), 32'(instr_ready), 32'h0);
            chk($sformatf("st_hold%0d_ce", k),    32'(alu_ce), 32'h0);
        end
        st_ready = 1'b1;
        @(negedge CLK);
        chk("st_done_valid", 32'(st_valid), 32'h0);
        chk("st_done_ready", 32'(instr_ready), 32'h1);
        chk("st_done_acc",   32'(acc), 32'hA5);

        // reset while a store is pending
        st_ready = 1'b0;
        issue(ST, 8'h00);
        @(negedge CLK);
        chk("rst_st_pre_valid", 32'(st_valid), 32'h1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_st_valid", 32'(st_valid), 32'h0);
        chk("rst_st_acc",   32'(acc), 32'h0);
        chk("rst_st_ready", 32'(instr_ready), 32'h1);
        @(negedge CLK) RST_N = 1'b1;
        issue(LD, 8'h77);
        @(negedge CLK);
        chk("post_rst_acc", 32'(acc), 32'h77);

        // reset during EXEC drops the in-flight instruction
        issue(ADD, 8'h05);
        chk("rst_exec_pre_ce", 32'(alu_ce), 32'h1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst_exec_acc",   32'(acc), 32'h0);
        chk("rst_exec_ce",    32'(alu_ce), 32'h0);
        chk("rst_exec_ready", 32'(instr_ready), 32'h1);
        @(negedge CLK) RST_N = 1'b1;
        @(negedge CLK);
        chk("rst_exec_after", 32'(acc), 32'h0);

`ifdef ALU_ZFLAG_EN
        issue(LD, 8'h55);
        @(negedge CLK);
        chk("z_ld", 32'(zero_flag), 32'h0);
        issue(XOR_, 8'h55);
        @(negedge CLK);
        chk("z_xor_acc", 32'(acc), 32'h0);
        chk("z_xor",     32'(zero_flag), 32'h1);
        issue(OR_, 8'h01);
        @(negedge CLK);
        chk("z_or", 32'(zero_flag), 32'h0);
`endif

        // randomized run from a clean reset
        #2 RST_N = 1'b0;
        @(negedge CLK) RST_N = 1'b1;
        m_acc = '0; m_c = 1'b0; m_z = 1'b1; m_st_out = 1'b0; m_st_data = '0;
        m_pend_v = 1'b0; m_pend_op = '0; m_pend_opnd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic          exp_ready, acc_ok, st_done;
            logic [SZ:0]   r;
            exp_ready = !(m_pend_v && m_pend_op == ST) && !m_st_out;
            chk("rnd_acc",      32'(acc), 32'(m_acc));
            chk("rnd_carry",    32'(carry_flag), 32'(m_c));
            chk("rnd_st_valid", 32'(st_valid), 32'(m_st_out));
            if (m_st_out) chk("rnd_st_data", 32'(st_data), 32'(m_st_data));
            chk("rnd_ready",    32'(instr_ready), 32'(exp_ready));
            chk("rnd_alu_ce",   32'(alu_ce), 32'(m_pend_v));
`ifdef ALU_ZFLAG_EN
            chk("rnd_zero",     32'(zero_flag), 32'(m_z));
`endif
            instr_valid   = ($urandom_range(0, 3) != 0);
            instr_op      = 3'($urandom_range(0, 7));
            instr_operand = 8'($urandom);
            st_ready      = ($urandom_range(0, 2) == 0);

            acc_ok  = instr_valid && exp_ready;
            st_done = m_st_out && st_ready;
            if (st_done) m_st_out = 1'b0;
            if (m_pend_v) begin
                r   = alu_fn(m_pend_op, m_acc, m_pend_opnd);
                m_z = (r[SZ-1:0] == '0);
                if (m_pend_op == ST) begin
                    m_st_out  = 1'b1;
                    m_st_data = r[SZ-1:0];
                end else begin
                    m_acc = r[SZ-1:0];
                    if (m_pend_op == ADD || m_pend_op == SUB) m_c = r[SZ];
                end
            end
            m_pend_v    = acc_ok;
            m_pend_op   = instr_op;
            m_pend_opnd = instr_operand;
            @(negedge CLK);
        end
        instr_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
